// File: rtl/cv32e40p_instr_bus_arbiter_if.sv
// Bundle of requester-side, bus-side and status signals for the instruction bus arbiter.
// The arbiter connects through the slave modport. The environment that drives the
// requesters and models the memory connects through the master modport.
interface cv32e40p_instr_bus_arbiter_if;

  // Port 0: prefetch controller
  logic        m0_req_i;
  logic [31:0] m0_addr_i;
  logic        m0_gnt_o;
  logic        m0_rvalid_o;

  // Port 1: secondary fetch master
  logic        m1_req_i;
  logic [31:0] m1_addr_i;
  logic        m1_gnt_o;
  logic        m1_rvalid_o;

  // Response data shared by both ports
  logic [31:0] rdata_o;
  logic        err_o;

  // OBI instruction-memory port
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;

  // Status
  logic        busy_o;
  logic        proto_err_o;

  modport slave (
    input  m0_req_i, m0_addr_i, m1_req_i, m1_addr_i,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
    output m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o,
    output rdata_o, err_o, instr_req_o, instr_addr_o,
    output busy_o, proto_err_o
  );

  modport master (
    output m0_req_i, m0_addr_i, m1_req_i, m1_addr_i,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
    input  m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o,
    input  rdata_o, err_o, instr_req_o, instr_addr_o,
    input  busy_o, proto_err_o
  );

endinterface

// File: rtl/cv32e40p_instr_bus_arbiter.sv
// Two-requester arbiter for the OBI instruction-memory port.
// Port 0 (prefetch) has fixed priority over port 1. Once a request is on the bus
// but not yet granted, it is held stable. Granted transactions are remembered
// in an ID FIFO so each in-order response is routed back to the port that issued it.
module cv32e40p_instr_bus_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  cv32e40p_instr_bus_arbiter_if.slave bus
);

  localparam int unsigned      PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e           state_q;
  state_e           state_d;

  logic             sel_q;
  logic [29:0]      addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             id_fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             proto_err_q;

  logic             req_any;
  logic             arb_sel;
  logic [29:0]      arb_addr;
  logic             gnt_sel;
  logic             bus_req;
  logic             handshake;
  logic             cnt_nonzero;
  logic             pop;
  logic             unexpected;
  logic             slot_free;
  logic             head_id;
  logic             unused_addr_lsbs;

  // Pointer advance that wraps at the FIFO depth, including non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // The byte-offset bits of the requester addresses are deliberately dropped.
  assign unused_addr_lsbs = ^{bus.m0_addr_i[1:0], bus.m1_addr_i[1:0]};

  // Bookkeeping for outstanding responses.
  // A response arriving while the counter is full frees a slot in the same cycle.
  assign cnt_nonzero = (cnt_q != '0);
  assign pop         = bus.instr_rvalid_i & cnt_nonzero;
  assign unexpected  = bus.instr_rvalid_i & ~cnt_nonzero;
  assign slot_free   = (cnt_q < CNT_MAX) | pop;
  assign head_id     = id_fifo_q[rd_ptr_q];

  // Fixed-priority pick between the two requesters; port 0 wins ties.
  always_comb begin
    req_any  = bus.m0_req_i | bus.m1_req_i;
    arb_sel  = ~bus.m0_req_i;
    arb_addr = bus.m0_req_i ? bus.m0_addr_i[31:2] : bus.m1_addr_i[31:2];
  end

  // State register for the ARB/HOLD controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB;
    else        state_q <= state_d;
  end

  // Go to HOLD when a bus request is left ungranted; return to ARB once it is granted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (bus_req && !bus.instr_gnt_i) state_d = HOLD;
      HOLD:    if (bus.instr_gnt_i)             state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Bus request, address, grants and response routing. In HOLD the latched request wins.
  always_comb begin
    gnt_sel          = arb_sel;
    bus_req          = req_any & slot_free;
    bus.instr_addr_o = req_any ? {arb_addr, 2'b00} : 32'h0;
    if (state_q == HOLD) begin
      gnt_sel          = sel_q;
      bus_req          = 1'b1;
      bus.instr_addr_o = {addr_q, 2'b00};
    end
    handshake        = bus_req & bus.instr_gnt_i;
    bus.instr_req_o  = bus_req;
    bus.m0_gnt_o     = handshake & ~gnt_sel;
    bus.m1_gnt_o     = handshake &  gnt_sel;
    bus.m0_rvalid_o  = pop & ~head_id;
    bus.m1_rvalid_o  = pop &  head_id;
    bus.rdata_o      = bus.instr_rdata_i;
    bus.err_o        = bus.instr_err_i;
    bus.busy_o       = cnt_nonzero | bus_req;
    bus.proto_err_o  = proto_err_q;
  end

  // Capture the winning port and address when its request is left waiting for a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= 1'b0;
      addr_q <= '0;
    end else if (state_q == ARB && state_d == HOLD) begin
      sel_q  <= arb_sel;
      addr_q <= arb_addr;
    end
  end

  // ID FIFO storage. Entries are only read after being written, so they need no reset.
  always_ff @(posedge clk) begin
    if (handshake) id_fifo_q[wr_ptr_q] <= gnt_sel;
  end

  // FIFO pointers and outstanding count. Push and pop advance independently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (handshake) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)       rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({handshake, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Sticky flag for a response that arrives with nothing outstanding; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          proto_err_q <= 1'b0;
    else if (unexpected) proto_err_q <= 1'b1;
  end

endmodule

// File: tb/tb_cv32e40p_instr_bus_arbiter.sv
// Self-checking bench for the instruction bus arbiter.
// Directed scenarios are checked against fixed expected values. A randomized run is
// checked against a transaction-level model that keeps a queue of outstanding port IDs.
module tb_cv32e40p_instr_bus_arbiter;

  localparam int MAX = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cv32e40p_instr_bus_arbiter_if bus();

  cv32e40p_instr_bus_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state: IDs of granted-but-unanswered fetches, oldest first, plus a pending
  // request that has been presented to the bus and is still waiting for a grant.
  int          ids_q[$];
  bit          pend;
  bit          pend_sel;
  logic [31:0] pend_addr;
  bit          perr;

  // Model outputs for the current cycle
  logic        e_req, e_sel, e_hs, e_popok;
  logic        e_m0_gnt, e_m1_gnt, e_m0_rv, e_m1_rv, e_busy;
  logic [31:0] e_addr;

  function void model_reset();
    ids_q.delete();
    pend      = 1'b0;
    pend_sel  = 1'b0;
    pend_addr = 32'h0;
    perr      = 1'b0;
  endfunction

  function void model_eval();
    bit any;
    any = bus.m0_req_i || bus.m1_req_i;
    if (pend) begin
      e_req  = 1'b1;
      e_sel  = pend_sel;
      e_addr = pend_addr;
    end else begin
      e_sel  = bus.m0_req_i ? 1'b0 : 1'b1;
      e_req  = any && (ids_q.size() < MAX || (bus.instr_rvalid_i && ids_q.size() > 0));
      e_addr = !any ? 32'h0 : (bus.m0_req_i ? bus.m0_addr_i : bus.m1_addr_i) & 32'hFFFF_FFFC;
    end
    e_hs     = e_req && bus.instr_gnt_i;
    e_m0_gnt = e_hs && (e_sel == 1'b0);
    e_m1_gnt = e_hs && (e_sel == 1'b1);
    e_popok  = bus.instr_rvalid_i && ids_q.size() > 0;
    e_m0_rv  = e_popok && ids_q[0] == 0;
    e_m1_rv  = e_popok && ids_q[0] == 1;
    e_busy   = ids_q.size() != 0 || e_req;
  endfunction

  function void model_advance();
    if (bus.instr_rvalid_i && ids_q.size() == 0) perr = 1'b1;
    if (e_popok) void'(ids_q.pop_front());
    if (e_hs) ids_q.push_back(int'(e_sel));
    pend      = e_req && !bus.instr_gnt_i;
    pend_sel  = e_sel;
    pend_addr = e_addr;
  endfunction

  task automatic set_in(input logic m0r, input logic [31:0] m0a, input logic m1r,
                        input logic [31:0] m1a, input logic gnt, input logic rv,
                        input logic [31:0] rd, input logic er);
    bus.m0_req_i       = m0r;
    bus.m0_addr_i      = m0a;
    bus.m1_req_i       = m1r;
    bus.m1_addr_i      = m1a;
    bus.instr_gnt_i    = gnt;
    bus.instr_rvalid_i = rv;
    bus.instr_rdata_i  = rd;
    bus.instr_err_i    = er;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.instr_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_req act=%0b exp=0", bus.instr_req_o); end
    checks++; if (bus.instr_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr act=%0h exp=0", bus.instr_addr_o); end
    checks++; if ({bus.m0_gnt_o, bus.m1_gnt_o, bus.m0_rvalid_o, bus.m1_rvalid_o} !== 4'b0) begin errors++; $display("[TB] FAIL reset_port_outs act=%0b exp=0", {bus.m0_gnt_o, bus.m1_gnt_o, bus.m0_rvalid_o, bus.m1_rvalid_o}); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy act=%0b exp=0", bus.busy_o); end
    checks++; if (bus.proto_err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_proto_err act=%0b exp=0", bus.proto_err_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_fetch();
    do_reset();
    set_in(1, 32'h0000_0103, 0, 0, 1, 0, 0, 0);
    #1;
    checks++; if (bus.instr_req_o !== 1'b1) begin errors++; $display("[TB] FAIL t1_req act=%0b exp=1", bus.instr_req_o); end
    checks++; if (bus.instr_addr_o !== 32'h100) begin errors++; $display("[TB] FAIL t1_addr act=%0h exp=100", bus.instr_addr_o); end
    checks++; if (bus.m0_gnt_o !== 1'b1 || bus.m1_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL t1_gnt act=%0b%0b exp=10", bus.m0_gnt_o, bus.m1_gnt_o); end
    tick();
    set_in(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
    #1;
    checks++; if (bus.m0_rvalid_o !== 1'b1 || bus.m1_rvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL t1_rvalid act=%0b%0b exp=10", bus.m0_rvalid_o, bus.m1_rvalid_o); end
    checks++; if (bus.rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL t1_rdata act=%0h exp=deadbeef", bus.rdata_o); end
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("[TB] FAIL t1_busy_outstanding act=%0b exp=1", bus.busy_o); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL t1_busy_idle act=%0b exp=0", bus.busy_o); end
  endtask

  task automatic test_priority();
    do_reset();
    set_in(1, 32'h0000_0400, 1, 32'h0000_0800, 1, 0, 0, 0);
    #1;
    checks++; if (bus.m0_gnt_o !== 1'b1 || bus.m1_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL t2_both_gnt act=%0b%0b exp=10", bus.m0_gnt_o, bus.m1_gnt_o); end
    checks++; if (bus.instr_addr_o !== 32'h400) begin errors++; $display("[TB] FAIL t2_both_addr act=%0h exp=400", bus.instr_addr_o); end
    tick();
    set_in(0, 32'h0000_0400, 1, 32'h0000_0800, 1, 0, 0, 0);
    #1;
    checks++; if (bus.m0_gnt_o !== 1'b0 || bus.m1_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL t2_m1_gnt act=%0b%0b exp=01", bus.m0_gnt_o, bus.m1_gnt_o); end
    checks++; if (bus.instr_addr_o !== 32'h800) begin errors++; $display("[TB] FAIL t2_m1_addr act=%0h exp=800", bus.instr_addr_o); end
    tick();
    set_in(0, 0, 0, 0, 0, 1, 32'h1111_1111, 0);
    #1;
    checks++; if (bus.m0_rvalid_o !== 1'b1 || bus.m1_rvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL t2_rsp0 act=%0b%0b exp=10", bus.m0_rvalid_o, bus.m1_rvalid_o); end
    tick();
    #1;
    checks++; if (bus.m0_rvalid_o !== 1'b0 || bus.m1_rvalid_o !== 1'b1) begin errors++; $display("[TB] FAIL t2_rsp1 act=%0b%0b exp=01", bus.m0_rvalid_o, bus.m1_rvalid_o); end
    tick();
  endtask

  task automatic test_hold();
    do_reset();
    set_in(0, 0, 1, 32'h0000_0200, 0, 0, 0, 0);
    #1;
    checks++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h200) begin errors++; $display("[TB] FAIL t3_c0 act=%0b/%0h exp=1/200", bus.instr_req_o, bus.instr_addr_o); end
    tick();
    set_in(1, 32'h0000_0300, 1, 32'h0000_0200, 0, 0, 0, 0);
    #1;
    checks++; if (bus.instr_addr_o !== 32'h200 || bus.m0_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL t3_c1 act=%0h/%0b exp=200/0", bus.instr_addr_o, bus.m0_gnt_o); end
    tick();
    set_in(1, 32'h0000_0300, 0, 32'h0000_0200, 0, 0, 0, 0);
    #1;
    checks++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h200) begin errors++; $display("[TB] FAIL t3_c2_dropped act=%0b/%0h exp=1/200", bus.instr_req_o, bus.instr_addr_o); end
    tick();
    set_in(1, 32'h0000_0300, 0, 32'h0000_0200, 1, 0, 0, 0);
    #1;
    checks++; if (bus.m1_gnt_o !== 1'b1 || bus.m0_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL t3_gnt act=%0b%0b exp=01", bus.m0_gnt_o, bus.m1_gnt_o); end
    checks++; if (bus.instr_addr_o !== 32'h200) begin errors++; $display("[TB] FAIL t3_gnt_addr act=%0h exp=200", bus.instr_addr_o); end
    tick();
    set_in(0, 0, 0, 0, 0, 1, 32'h2222_2222, 0);
    #1;
    checks++; if (bus.m1_rvalid_o !== 1'b1 || bus.m0_rvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL t3_rsp act=%0b%0b exp=01", bus.m0_rvalid_o, bus.m1_rvalid_o); end
    tick();
  endtask

  task automatic test_outstanding_limit();
    do_reset();
    set_in(1, 32'h0000_1000, 0, 0, 1, 0, 0, 0);
    tick();
    tick();
    set_in(1, 32'h0000_1000, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (bus.instr_req_o !== 1'b0) begin errors++; $display("[TB] FAIL t4_full_req act=%0b exp=0", bus.instr_req_o); end
    set_in(1, 32'h0000_1000, 0, 0, 1, 1, 32'h3333_3333, 0);
    #1;
    checks++; if (bus.instr_req_o !== 1'b1 || bus.m0_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL t4_free_slot act=%0b/%0b exp=1/1", bus.instr_req_o, bus.m0_gnt_o); end
    checks++; if (bus.m0_rvalid_o !== 1'b1) begin errors++; $display("[TB] FAIL t4_free_rvalid act=%0b exp=1", bus.m0_rvalid_o); end
    tick();
    set_in(1, 32'h0000_1000, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (bus.instr_req_o !== 1'b0 || bus.busy_o !== 1'b1) begin errors++; $display("[TB] FAIL t4_still_full act=%0b/%0b exp=0/1", bus.instr_req_o, bus.busy_o); end
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL t4_drained act=%0b exp=0", bus.busy_o); end
  endtask

  task automatic test_routing();
    do_reset();
    set_in(1, 32'h0000_0010, 0, 0, 1, 0, 0, 0);
    tick();
    set_in(0, 0, 1, 32'h0000_0020, 1, 0, 0, 0);
    tick();
    set_in(1, 32'h0000_0030, 0, 0, 1, 1, 32'hAAAA_0001, 0);
    #1;
    checks++; if (bus.m0_rvalid_o !== 1'b1 || bus.m1_rvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL t5_rsp1 act=%0b%0b exp=10", bus.m0_rvalid_o, bus.m1_rvalid_o); end
    checks++; if (bus.m0_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL t5_third_gnt act=%0b exp=1", bus.m0_gnt_o); end
    tick();
    set_in(0, 0, 0, 0, 0, 1, 32'hAAAA_0002, 1);
    #1;
    checks++; if (bus.m0_rvalid_o !== 1'b0 || bus.m1_rvalid_o !== 1'b1) begin errors++; $display("[TB] FAIL t5_rsp2 act=%0b%0b exp=01", bus.m0_rvalid_o, bus.m1_rvalid_o); end
    checks++; if (bus.err_o !== 1'b1 || bus.rdata_o !== 32'hAAAA_0002) begin errors++; $display("[TB] FAIL t5_rsp2_err act=%0b/%0h exp=1/aaaa0002", bus.err_o, bus.rdata_o); end
    tick();
    set_in(0, 0, 0, 0, 0, 1, 32'hAAAA_0003, 0);
    #1;
    checks++; if (bus.m0_rvalid_o !== 1'b1 || bus.m1_rvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL t5_rsp3 act=%0b%0b exp=10", bus.m0_rvalid_o, bus.m1_rvalid_o); end
    tick();
  endtask

  task automatic test_unexpected_response();
    do_reset();
    set_in(0, 0, 0, 0, 0, 1, 32'h5555_5555, 0);
    #1;
    checks++; if (bus.m0_rvalid_o !== 1'b0 || bus.m1_rvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL t6_no_rvalid act=%0b%0b exp=00", bus.m0_rvalid_o, bus.m1_rvalid_o); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    #1;
    checks++; if (bus.proto_err_o !== 1'b1) begin errors++; $display("[TB] FAIL t6_sticky act=%0b exp=1", bus.proto_err_o); end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.proto_err_o !== 1'b0) begin errors++; $display("[TB] FAIL t6_cleared act=%0b exp=0", bus.proto_err_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_transaction();
    do_reset();
    set_in(1, 32'h0000_0040, 0, 0, 1, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy act=%0b exp=0", bus.busy_o); end
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 1, 32'h7777_7777, 0);
    #1;
    checks++; if (bus.m0_rvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_rvalid act=%0b exp=0", bus.m0_rvalid_o); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (bus.proto_err_o !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_proto_err act=%0b exp=1", bus.proto_err_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      set_in(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
             1'($urandom_range(0, 2) != 0), 1'(ids_q.size() > 0 && $urandom_range(0, 2) != 0),
             $urandom, 1'($urandom_range(0, 1)));
      #1;
      model_eval();
      checks++; if (bus.instr_req_o !== e_req) begin errors++; $display("[TB] FAIL rnd_req cyc=%0d act=%0b exp=%0b", cyc, bus.instr_req_o, e_req); end
      checks++; if (bus.instr_addr_o !== e_addr) begin errors++; $display("[TB] FAIL rnd_addr cyc=%0d act=%0h exp=%0h", cyc, bus.instr_addr_o, e_addr); end
      checks++; if (bus.m0_gnt_o !== e_m0_gnt || bus.m1_gnt_o !== e_m1_gnt) begin errors++; $display("[TB] FAIL rnd_gnt cyc=%0d act=%0b%0b exp=%0b%0b", cyc, bus.m0_gnt_o, bus.m1_gnt_o, e_m0_gnt, e_m1_gnt); end
      checks++; if (bus.m0_rvalid_o !== e_m0_rv || bus.m1_rvalid_o !== e_m1_rv) begin errors++; $display("[TB] FAIL rnd_rvalid cyc=%0d act=%0b%0b exp=%0b%0b", cyc, bus.m0_rvalid_o, bus.m1_rvalid_o, e_m0_rv, e_m1_rv); end
      checks++; if (bus.rdata_o !== bus.instr_rdata_i || bus.err_o !== bus.instr_err_i) begin errors++; $display("[TB] FAIL rnd_rdata cyc=%0d act=%0h/%0b exp=%0h/%0b", cyc, bus.rdata_o, bus.err_o, bus.instr_rdata_i, bus.instr_err_i); end
      checks++; if (bus.busy_o !== e_busy) begin errors++; $display("[TB] FAIL rnd_busy cyc=%0d act=%0b exp=%0b", cyc, bus.busy_o, e_busy); end
      checks++; if (bus.proto_err_o !== perr) begin errors++; $display("[TB] FAIL rnd_proto_err cyc=%0d act=%0b exp=%0b", cyc, bus.proto_err_o, perr); end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_single_fetch();
    test_priority();
    test_hold();
    test_outstanding_limit();
    test_routing();
    test_unexpected_response();
    test_reset_mid_transaction();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
